csr_trap_unit: RTL

- Machine-mode CSR file and trap sequencer for the single-cycle RV32 core.
- Consumes the CSR and return-from-interrupt controls produced by instruction decode.
- Executes CSRRW/RS/RC and their immediate forms, owns the interrupt state, takes external and timer interrupts, and executes MRET.
- Drives the PC redirect and the CSR read data that goes to register-file writeback.

---
 rtl/csr_trap_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and interrupt trap sequencer
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        csr_wen,
  input  logic        csr_sel,
  input  logic [2:0]  fn3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_taken
);

  logic        st_mie, st_mpie, meie, mtie;
  logic [31:0] mtvec, mscratch, mepc, mcause;
  logic [63:0] mcycle, minstret;
  logic [31:0] old_val, op, new_val;
  logic        pend_e, pend_t, fn_write, do_write, do_mret, retire;

  assign pend_e     = ext_irq & meie;
  assign pend_t     = timer_irq & mtie;
  assign trap_taken = instr_valid & st_mie & (pend_e | pend_t);
  assign do_mret    = instr_valid & mret & ~trap_taken;
  assign retire     = instr_valid & ~trap_taken;

  assign redirect_valid = trap_taken | do_mret;
  assign redirect_pc    = trap_taken ? mtvec : (do_mret ? mepc : 32'h0);

  always_comb begin
    old_val = 32'h0;
    case (csr_addr)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      12'h304: old_val = {20'b0, meie, 3'b0, mtie, 7'b0};
      12'h305: old_val = mtvec;
      12'h340: old_val = mscratch;
      12'h341: old_val = mepc;
      12'h342: old_val = mcause;
      12'h344: old_val = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
      12'hB00: old_val = HAS_COUNTERS ? mcycle[31:0]    : 32'h0;
      12'hB80: old_val = HAS_COUNTERS ? mcycle[63:32]   : 32'h0;
      12'hB02: old_val = HAS_COUNTERS ? minstret[31:0]  : 32'h0;
      12'hB82: old_val = HAS_COUNTERS ? minstret[63:32] : 32'h0;
      default: old_val = 32'h0;
    endcase
  end

  assign csr_rdata = csr_wen ? old_val : 32'h0;
  assign op        = csr_sel ? {27'b0, zimm} : rs1_data;

  always_comb begin
    fn_write = 1'b1;
    new_val  = op;
    case (fn3)
      3'b001, 3'b101: new_val = op;
      3'b010, 3'b110: new_val = old_val | op;
      3'b011, 3'b111: new_val = old_val & ~op;
      default:        fn_write = 1'b0;
    endcase
  end

  assign do_write = instr_valid & csr_wen & ~trap_taken & fn_write;

  // A trap wins over the squashed instruction's CSR write and MRET.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      meie     <= 1'b0;
      mtie     <= 1'b0;
      mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch <= 32'h0;
      mepc     <= 32'h0;
      mcause   <= 32'h0;
    end else if (trap_taken) begin
      mepc    <= {pc[31:2], 2'b00};
      mcause  <= pend_e ? 32'h8000_000B : 32'h8000_0007;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else begin
      if (do_write) begin
        case (csr_addr)
          12'h300: begin
            st_mie  <= new_val[3];
            st_mpie <= new_val[7];
          end
          12'h304: begin
            meie <= new_val[11];
            mtie <= new_val[7];
          end
          12'h305: mtvec    <= {new_val[31:2], 2'b00};
          12'h340: mscratch <= new_val;
          12'h341: mepc     <= {new_val[31:2], 2'b00};
          12'h342: mcause   <= new_val;
          default: ;
        endcase
      end
      if (do_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  // Writing one half replaces that cycle's increment; the other half holds.
  always_ff @(posedge clk) begin
    if (rst || !HAS_COUNTERS) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (do_write && csr_addr == 12'hB00)
        mcycle <= {mcycle[63:32], new_val};
      else if (do_write && csr_addr == 12'hB80)
        mcycle <= {new_val, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (do_write && csr_addr == 12'hB02)
        minstret <= {minstret[63:32], new_val};
      else if (do_write && csr_addr == 12'hB82)
        minstret <= {new_val, minstret[31:0]};
      else if (retire)
        minstret <= minstret + 64'd1;
    end
  end

endmodule
